// File: rtl/dcache_drain_ctrl_pkg.sv
// dcache_pkg: shared types and address-split helpers for the store-buffer
// drain controller and its tag array.
//   state_t    : controller FSM states
//   sb_entry_t : captured store-buffer entry {addr, data}
//   off_w/idx_w/tag_w : byte-offset, index and tag widths of a 32-bit address
package dcache_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        CAPT  = 3'd2,
        WB    = 3'd3,
        FILL  = 3'd4,
        WRITE = 3'd5
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_entry_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words) + 32'sd2;
    endfunction

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int num_lines, input int line_words);
        return 32'sd32 - idx_w(num_lines) - off_w(line_words);
    endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// dcache_tag_array: valid/dirty/tag storage of the direct-mapped cache.
// Two combinational lookups (the entry being processed and the pipeline
// lookup address) and synchronous updates at the entry's index.
//   clk, reset          : clock, synchronous active-high reset (clears valid/dirty)
//   ent_line            : entry address without byte offset {tag, idx}
//   lk_line             : pipeline lookup address without byte offset
//   ent_hit/valid/dirty : lookup result at the entry's index
//   ent_tag             : stored tag at the entry's index (victim tag on a miss)
//   lk_hit              : valid && tag match for the pipeline lookup
//   fill_we             : install entry tag, valid=1, dirty=0
//   set_dirty/clr_dirty : mark line dirty / clean
module dcache_tag_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = 4,
    parameter int LINE_WORDS = 4,
    localparam int IDX_W     = idx_w(NUM_LINES),
    localparam int TAG_W     = tag_w(NUM_LINES, LINE_WORDS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [TAG_W+IDX_W-1:0] ent_line,
    input  logic [TAG_W+IDX_W-1:0] lk_line,
    output logic                   ent_hit,
    output logic                   ent_valid,
    output logic                   ent_dirty,
    output logic [TAG_W-1:0]       ent_tag,
    output logic                   lk_hit,
    input  logic                   fill_we,
    input  logic                   set_dirty,
    input  logic                   clr_dirty
);

    logic [NUM_LINES-1:0] valid_r;
    logic [NUM_LINES-1:0] dirty_r;
    logic [TAG_W-1:0]     tag_r [NUM_LINES];

    logic [IDX_W-1:0] ent_idx_s;
    logic [TAG_W-1:0] ent_tg_s;
    logic [IDX_W-1:0] lk_idx_s;
    logic [TAG_W-1:0] lk_tg_s;

    assign ent_idx_s = ent_line[IDX_W-1:0];
    assign ent_tg_s  = ent_line[TAG_W+IDX_W-1:IDX_W];
    assign lk_idx_s  = lk_line[IDX_W-1:0];
    assign lk_tg_s   = lk_line[TAG_W+IDX_W-1:IDX_W];

    // Combinational dual lookup against current array contents.
    always_comb begin
        ent_valid = valid_r[ent_idx_s];
        ent_dirty = dirty_r[ent_idx_s];
        ent_tag   = tag_r[ent_idx_s];
        ent_hit   = valid_r[ent_idx_s] && (tag_r[ent_idx_s] == ent_tg_s);
        lk_hit    = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tg_s);
    end

    // Valid/dirty state; reset invalidates every line.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= '0;
            dirty_r <= '0;
        end else if (fill_we) begin
            valid_r[ent_idx_s] <= 1'b1;
            dirty_r[ent_idx_s] <= 1'b0;
        end else if (set_dirty) begin
            dirty_r[ent_idx_s] <= 1'b1;
        end else if (clr_dirty) begin
            dirty_r[ent_idx_s] <= 1'b0;
        end
    end

    // Tag storage; not reset since valid bits guard it.
    always_ff @(posedge clk) begin
        if (fill_we && !reset) begin
            tag_r[ent_idx_s] <= ent_tg_s;
        end
    end

endmodule

// File: rtl/dcache_drain_ctrl.sv
// dcache_drain_ctrl: cache-side endpoint of the store-buffer drain interface.
// Polls the store buffer with a one-cycle sb_ready pulse, captures one
// {addr,data} entry, and commits it into a direct-mapped write-back array,
// doing a dirty-victim writeback and line fill over the mem_* port on a miss.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   sb_ready/valid/data   : drain handshake; sb_data = {addr[31:0], data[31:0]}
//   lk_addr, lk_hit       : combinational tag-hit lookup for the pipeline
//   busy                  : FSM not in IDLE
//   mem_req/we/addr/wdata : line request (we=1 writeback, we=0 fill), held to ack
//   mem_rdata, mem_ack    : fill data and one-cycle completion strobe
// Optional macro DCACHE_DRAIN_STATS_EN adds stat_hits/stat_misses/stat_wbs.
module dcache_drain_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     sb_ready,
    input  logic                     sb_valid,
    input  logic [63:0]              sb_data,
    input  logic [31:0]              lk_addr,
    output logic                     lk_hit,
    output logic                     busy,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [32*LINE_WORDS-1:0] mem_wdata,
    input  logic [32*LINE_WORDS-1:0] mem_rdata,
    input  logic                     mem_ack
`ifdef DCACHE_DRAIN_STATS_EN
    ,
    output logic [31:0]              stat_hits,
    output logic [31:0]              stat_misses,
    output logic [31:0]              stat_wbs
`endif
);

    localparam int OFF_W  = off_w(LINE_WORDS);
    localparam int IDX_W  = idx_w(NUM_LINES);
    localparam int TAG_W  = tag_w(NUM_LINES, LINE_WORDS);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int LINE_W = 32 * LINE_WORDS;

    state_t            state_r;
    sb_entry_t         entry_r;
    logic              sb_ready_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [31:0]       mem_addr_r;
    logic [LINE_W-1:0] mem_wdata_r;
    logic [LINE_W-1:0] data_r [NUM_LINES];

    sb_entry_t         sb_in_s;
    logic [31:0]       look_addr_s;
    logic [IDX_W-1:0]  look_idx_s;
    logic [WORD_W-1:0] word_s;
    logic              ent_hit_s;
    logic              ent_valid_s;
    logic              ent_dirty_s;
    logic [TAG_W-1:0]  ent_tag_s;
    logic              fill_we_s;
    logic              clr_dirty_s;
    logic              wr_word_s;
    logic              lint_unused_s;

    assign sb_in_s = sb_data;

    // In CAPT the entry register is not loaded yet, so look up the incoming address.
    always_comb begin
        if (state_r == CAPT) begin
            look_addr_s = sb_in_s.addr;
        end else begin
            look_addr_s = entry_r.addr;
        end
    end

    assign look_idx_s  = look_addr_s[OFF_W +: IDX_W];
    assign word_s      = entry_r.addr[OFF_W-1:2];
    assign fill_we_s   = (state_r == FILL) && mem_req_r && mem_ack;
    assign clr_dirty_s = (state_r == WB) && mem_ack;
    assign wr_word_s   = (state_r == WRITE);

    assign lint_unused_s = ^{lk_addr[OFF_W-1:0], look_addr_s[OFF_W-1:0], entry_r.addr[1:0]};

    dcache_tag_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_tags (
        .clk       (clk),
        .reset     (reset),
        .ent_line  (look_addr_s[31:OFF_W]),
        .lk_line   (lk_addr[31:OFF_W]),
        .ent_hit   (ent_hit_s),
        .ent_valid (ent_valid_s),
        .ent_dirty (ent_dirty_s),
        .ent_tag   (ent_tag_s),
        .lk_hit    (lk_hit),
        .fill_we   (fill_we_s),
        .set_dirty (wr_word_s),
        .clr_dirty (clr_dirty_s)
    );

    // Line data: whole-line fill on ack, single-word store in WRITE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fill_we_s) begin
                data_r[look_idx_s] <= mem_rdata;
            end else if (wr_word_s) begin
                data_r[look_idx_s][{word_s, 5'd0} +: 32] <= entry_r.data;
            end
        end
    end

    // Drain FSM with registered handshake and memory-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            entry_r     <= '0;
            sb_ready_r  <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    sb_ready_r <= 1'b1;
                    state_r    <= REQ;
                end
                REQ: begin
                    sb_ready_r <= 1'b0;
                    state_r    <= CAPT;
                end
                CAPT: begin
                    if (sb_valid) begin
                        entry_r <= sb_in_s;
                        if (ent_hit_s) begin
                            state_r <= WRITE;
                        end else if (ent_valid_s && ent_dirty_s) begin
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= {ent_tag_s, look_idx_s, {OFF_W{1'b0}}};
                            mem_wdata_r <= data_r[look_idx_s];
                            state_r     <= WB;
                        end else begin
                            mem_req_r  <= 1'b1;
                            mem_we_r   <= 1'b0;
                            mem_addr_r <= {sb_in_s.addr[31:OFF_W], {OFF_W{1'b0}}};
                            state_r    <= FILL;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        mem_req_r <= 1'b0;
                        state_r   <= FILL;
                    end
                end
                FILL: begin
                    // After a writeback the request drops for one cycle, then re-raises as a fill.
                    if (!mem_req_r) begin
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= {entry_r.addr[31:OFF_W], {OFF_W{1'b0}}};
                    end else if (mem_ack) begin
                        mem_req_r <= 1'b0;
                        state_r   <= WRITE;
                    end
                end
                WRITE: begin
                    state_r <= IDLE;
                end
                default: begin
                    sb_ready_r <= 1'b0;
                    mem_req_r  <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign sb_ready  = sb_ready_r;
    assign busy      = (state_r != IDLE);
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

`ifdef DCACHE_DRAIN_STATS_EN
    logic [31:0] stat_hits_r;
    logic [31:0] stat_misses_r;
    logic [31:0] stat_wbs_r;

    // Event counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hits_r   <= 32'd0;
            stat_misses_r <= 32'd0;
            stat_wbs_r    <= 32'd0;
        end else begin
            if ((state_r == CAPT) && sb_valid && ent_hit_s) begin
                stat_hits_r <= stat_hits_r + 32'd1;
            end
            if ((state_r == CAPT) && sb_valid && !ent_hit_s) begin
                stat_misses_r <= stat_misses_r + 32'd1;
            end
            if (clr_dirty_s) begin
                stat_wbs_r <= stat_wbs_r + 32'd1;
            end
        end
    end

    assign stat_hits   = stat_hits_r;
    assign stat_misses = stat_misses_r;
    assign stat_wbs    = stat_wbs_r;
`endif

endmodule
